// File: rtl/counter_sequencer.sv
// Command-driven up/down/bounce counter sequencer; count is valid the cycle after accept, pulses are registered.
// Commands are accepted only in IDLE (cmd_ready); commands offered while busy are dropped, not queued.
module counter_sequencer #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [N-1:0] cmd_start,
    input  logic [N-1:0] cmd_end,
    input  logic [1:0]   cmd_mode,
    input  logic         cmd_reload,
    input  logic         pause,
    input  logic         abort,
    output logic [N-1:0] count,
    output logic         dir,
    output logic         busy,
    output logic         tc_pulse,
    output logic         done_pulse
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [1:0]   MODE_DOWN   = 2'b01;
    localparam logic [1:0]   MODE_BOUNCE = 2'b10;
    localparam logic [N-1:0] ONE         = {{(N-1){1'b0}}, 1'b1};

    state_t       state, state_nxt;
    logic [N-1:0] count_nxt;
    logic         dir_nxt;
    logic         tc_nxt, done_nxt;
    logic [N-1:0] start_q, start_nxt;
    logic [N-1:0] end_q, end_nxt;
    logic [1:0]   mode_q, mode_nxt;
    logic         reload_q, reload_nxt;

    logic         bounce;
    logic         terminal;
    logic [N-1:0] wrap_count;
    logic         wrap_dir;

    assign cmd_ready = (state == IDLE) && !rst;
    assign busy      = (state == RUN);

    always_comb begin
        state_nxt  = state;
        count_nxt  = count;
        dir_nxt    = dir;
        start_nxt  = start_q;
        end_nxt    = end_q;
        mode_nxt   = mode_q;
        reload_nxt = reload_q;
        tc_nxt     = 1'b0;
        done_nxt   = 1'b0;
        terminal   = 1'b0;
        wrap_count = start_q;
        wrap_dir   = dir;
        // A bounce with no room to travel degenerates to a held start value.
        bounce     = (mode_q == MODE_BOUNCE) && (start_q < end_q);

        case (state)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    start_nxt  = cmd_start;
                    end_nxt    = cmd_end;
                    mode_nxt   = cmd_mode;
                    reload_nxt = cmd_reload;
                    count_nxt  = cmd_start;
                    dir_nxt    = (cmd_mode != MODE_DOWN);
                    state_nxt  = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (!pause) begin
                    if (bounce) begin
                        if (dir && count == end_q) begin
                            dir_nxt   = 1'b0;
                            count_nxt = end_q - ONE;
                        end else if (!dir && count == start_q) begin
                            terminal   = 1'b1;
                            wrap_count = start_q + ONE;
                            wrap_dir   = 1'b1;
                        end else begin
                            count_nxt = dir ? count + ONE : count - ONE;
                        end
                    end else if (mode_q == MODE_BOUNCE || count == end_q) begin
                        terminal = 1'b1;
                    end else if (mode_q == MODE_DOWN) begin
                        count_nxt = count - ONE;
                    end else begin
                        count_nxt = count + ONE;
                    end

                    if (terminal) begin
                        tc_nxt = 1'b1;
                        if (reload_q) begin
                            count_nxt = wrap_count;
                            dir_nxt   = wrap_dir;
                        end else begin
                            state_nxt = IDLE;
                            done_nxt  = 1'b1;
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            count      <= '0;
            dir        <= 1'b1;
            tc_pulse   <= 1'b0;
            done_pulse <= 1'b0;
            start_q    <= '0;
            end_q      <= '0;
            mode_q     <= 2'b00;
            reload_q   <= 1'b0;
        end else begin
            state      <= state_nxt;
            count      <= count_nxt;
            dir        <= dir_nxt;
            tc_pulse   <= tc_nxt;
            done_pulse <= done_nxt;
            start_q    <= start_nxt;
            end_q      <= end_nxt;
            mode_q     <= mode_nxt;
            reload_q   <= reload_nxt;
        end
    end

endmodule

// File: tb/tb_counter_sequencer.sv
// Bench for counter_sequencer: vector table, directed corner sequences, then random traffic against a profile-list model.
module tb_counter_sequencer;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst, cmd_valid, cmd_ready, cmd_reload, pause, abort;
    logic [N-1:0] cmd_start, cmd_end, count;
    logic [1:0]   cmd_mode;
    logic         dir, busy, tc_pulse, done_pulse;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    counter_sequencer #(.N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_start  (cmd_start),
        .cmd_end    (cmd_end),
        .cmd_mode   (cmd_mode),
        .cmd_reload (cmd_reload),
        .pause      (pause),
        .abort      (abort),
        .count      (count),
        .dir        (dir),
        .busy       (busy),
        .tc_pulse   (tc_pulse),
        .done_pulse (done_pulse)
    );

    typedef struct {
        logic       r, cv;
        logic [7:0] s, e;
        logic [1:0] m;
        logic       rl, p, a;
        logic [7:0] c;
        logic       d, b, tc, dn, rdy;
    } vec_t;

    vec_t vecs[18];

    function automatic vec_t mk(input logic r, cv, input logic [7:0] s, e, input logic [1:0] m,
                                input logic rl, p, a, input logic [7:0] c,
                                input logic d, b, tc, dn, rdy);
        vec_t v;
        v.r = r; v.cv = cv; v.s = s; v.e = e; v.m = m; v.rl = rl; v.p = p; v.a = a;
        v.c = c; v.d = d; v.b = b; v.tc = tc; v.dn = dn; v.rdy = rdy;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, cv, input logic [7:0] s, e, input logic [1:0] m,
                         input logic rl, p, a);
        rst = r; cmd_valid = cv; cmd_start = s; cmd_end = e; cmd_mode = m;
        cmd_reload = rl; pause = p; abort = a;
    endtask

    task automatic idle_in();
        drive(1'b0, 1'b0, 8'd0, 8'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [7:0] c, input logic d, b, tc, dn, rdy);
        chk({tag, " count"}, count, c);
        chk({tag, " dir"}, dir, d);
        chk({tag, " busy"}, busy, b);
        chk({tag, " tc"}, tc_pulse, tc);
        chk({tag, " done"}, done_pulse, dn);
        chk({tag, " ready"}, cmd_ready, rdy);
    endtask

    // Reference model: one period of the count profile is expanded into a list of values.
    logic [7:0] mseq[$];
    int         midx, mridx, mapex;
    bit         m_busy, m_bounce, m_updir, m_reload, m_dir, m_tc, m_done;
    logic [7:0] m_count;

    function automatic void m_view();
        m_count = mseq[midx];
        m_dir   = m_bounce ? (midx <= mapex) : m_updir;
    endfunction

    function automatic void m_accept(input int s, e, input logic [1:0] m, input bit rl);
        int len;
        mseq.delete();
        m_bounce = (m == 2'b10) && (s < e);
        mridx    = 0;
        if (m_bounce) begin
            mapex = e - s;
            for (int k = 0; k <= e - s; k++) mseq.push_back(8'(s + k));
            for (int k = e - s - 1; k >= 0; k--) mseq.push_back(8'(s + k));
            mridx = 1;
        end else if (m == 2'b10) begin
            mseq.push_back(8'(s));
        end else if (m == 2'b01) begin
            len = ((s - e) & 255) + 1;
            for (int k = 0; k < len; k++) mseq.push_back(8'(s - k));
        end else begin
            len = ((e - s) & 255) + 1;
            for (int k = 0; k < len; k++) mseq.push_back(8'(s + k));
        end
        m_updir  = (m != 2'b01);
        m_reload = rl;
        midx     = 0;
        m_busy   = 1'b1;
        m_view();
    endfunction

    function automatic void m_step(input bit r, cv, input logic [7:0] s, e, input logic [1:0] m,
                                   input bit rl, p, a);
        m_tc   = 1'b0;
        m_done = 1'b0;
        if (r) begin
            m_busy = 1'b0; m_count = 8'd0; m_dir = 1'b1;
        end else if (!m_busy) begin
            if (cv) m_accept(s, e, m, rl);
        end else if (a) begin
            m_busy = 1'b0;
        end else if (!p) begin
            if (midx == mseq.size() - 1) begin
                m_tc = 1'b1;
                if (m_reload) midx = mridx;
                else begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                end
            end else begin
                midx++;
            end
            m_view();
        end
    endfunction

    // Bounce reload 1..3: expected count/dir/tc after each edge, pause held on three of them.
    logic [7:0] b_cnt[13] = '{8'd2, 8'd3, 8'd2, 8'd1, 8'd2, 8'd3, 8'd3, 8'd3, 8'd3, 8'd2, 8'd1, 8'd2, 8'd3};
    logic       b_dir[13] = '{1, 1, 0, 0, 1, 1, 1, 1, 1, 0, 0, 1, 1};
    logic       b_tc[13]  = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0};
    logic       b_pau[13] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0};

    initial begin
        vecs[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0, 0);
        vecs[1]  = mk(1, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0, 0);
        vecs[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0, 1);
        vecs[3]  = mk(0, 1, 3, 6, 0, 0, 0, 0,  3, 1, 1, 0, 0, 0);
        vecs[4]  = mk(0, 0, 0, 0, 0, 0, 0, 0,  4, 1, 1, 0, 0, 0);
        vecs[5]  = mk(0, 0, 0, 0, 0, 0, 0, 0,  5, 1, 1, 0, 0, 0);
        vecs[6]  = mk(0, 0, 0, 0, 0, 0, 0, 0,  6, 1, 1, 0, 0, 0);
        vecs[7]  = mk(0, 0, 0, 0, 0, 0, 0, 0,  6, 1, 0, 1, 1, 1);
        vecs[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0,  6, 1, 0, 0, 0, 1);
        vecs[9]  = mk(0, 1, 2, 0, 1, 1, 0, 0,  2, 0, 1, 0, 0, 0);
        vecs[10] = mk(0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 1, 0, 0, 0);
        vecs[11] = mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0);
        vecs[12] = mk(0, 0, 0, 0, 0, 0, 0, 0,  2, 0, 1, 1, 0, 0);
        vecs[13] = mk(0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 1, 0, 0, 0);
        vecs[14] = mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0);
        vecs[15] = mk(0, 0, 0, 0, 0, 0, 0, 0,  2, 0, 1, 1, 0, 0);
        vecs[16] = mk(0, 0, 0, 0, 0, 0, 0, 1,  2, 0, 0, 0, 0, 1);
        vecs[17] = mk(0, 0, 0, 0, 0, 0, 0, 0,  2, 0, 0, 0, 0, 1);

        idle_in();
        #2;
        for (int i = 0; i < 18; i++) begin
            drive(vecs[i].r, vecs[i].cv, vecs[i].s, vecs[i].e, vecs[i].m,
                  vecs[i].rl, vecs[i].p, vecs[i].a);
            tick();
            chk_all($sformatf("vec%0d", i), vecs[i].c, vecs[i].d, vecs[i].b,
                    vecs[i].tc, vecs[i].dn, vecs[i].rdy);
        end

        // Bounce with reload and a mid-run pause.
        drive(0, 1, 8'd1, 8'd3, 2'b10, 1, 0, 0);
        tick();
        chk_all("bounce accept", 8'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 13; i++) begin
            drive(0, 0, 8'd0, 8'd0, 2'd0, 0, b_pau[i], 0);
            tick();
            chk($sformatf("bounce%0d count", i), count, b_cnt[i]);
            chk($sformatf("bounce%0d dir", i), dir, b_dir[i]);
            chk($sformatf("bounce%0d tc", i), tc_pulse, b_tc[i]);
        end
        drive(0, 0, 8'd0, 8'd0, 2'd0, 0, 0, 1);
        tick();
        chk_all("bounce abort", 8'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

        // Wrap through 255 -> 0 with an ignored command while busy, then back-to-back accept.
        drive(0, 1, 8'd254, 8'd1, 2'b00, 0, 0, 0);
        tick();
        chk_all("wrap accept", 8'd254, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(0, 1, 8'd100, 8'd120, 2'b01, 1, 0, 0);
        #1;
        chk("busy cmd_ready", cmd_ready, 1'b0);
        tick();
        chk("wrap 255", count, 8'd255);
        idle_in();
        tick();
        chk("wrap 0", count, 8'd0);
        tick();
        chk_all("wrap 1", 8'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        chk_all("wrap done", 8'd1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        drive(0, 1, 8'd10, 8'd11, 2'b00, 0, 0, 0);
        tick();
        chk_all("b2b accept", 8'd10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        idle_in();
        tick();
        chk("b2b 11", count, 8'd11);
        drive(1, 0, 8'd0, 8'd0, 2'd0, 0, 0, 1);
        tick();
        chk_all("rst+abort", 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Random traffic against the model.
        m_step(1, 0, 0, 0, 0, 0, 0, 0);
        tick();
        for (int cyc = 0; cyc < 4000; cyc++) begin
            logic       r, cv, rl, p, a;
            logic [7:0] s, e;
            logic [1:0] m;
            r  = ($urandom_range(0, 299) == 0);
            cv = ($urandom_range(0, 2) == 0);
            s  = 8'($urandom_range(0, 255));
            e  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                             : 8'(s + $urandom_range(0, 12));
            m  = 2'($urandom_range(0, 3));
            rl = 1'($urandom_range(0, 1));
            p  = ($urandom_range(0, 7) == 0);
            a  = ($urandom_range(0, 49) == 0);
            drive(r, cv, s, e, m, rl, p, a);
            #1;
            chk($sformatf("rnd%0d ready", cyc), cmd_ready, !m_busy && !r);
            m_step(r, cv, s, e, m, rl, p, a);
            tick();
            chk($sformatf("rnd%0d count", cyc), count, m_count);
            chk($sformatf("rnd%0d dir", cyc), dir, m_dir);
            chk($sformatf("rnd%0d busy", cyc), busy, m_busy);
            chk($sformatf("rnd%0d tc", cyc), tc_pulse, m_tc);
            chk($sformatf("rnd%0d done", cyc), done_pulse, m_done);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/counter_sequencer.md
Name: counter_sequencer

Overview:
- Command-driven controller that sequences an N-bit counter datapath through up, down and bounce (up-then-down) count profiles between programmable start and end values.
- Supports one-shot and auto-reload operation, pause and abort.
- Reports terminal-count and completion events so that timing, PWM and test-pattern logic can share one counter under firmware or FSM control.

Parameters:
- N, 8, counter and bound width in bits.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command. Equals 1 only when state is IDLE and rst is 0.
- cmd_start  in  N  start value, latched on accept.
- cmd_end  in  N  end/terminal value, latched on accept.
- cmd_mode  in  2  00 up, 01 down, 10 bounce, 11 reserved (executes as up).
- cmd_reload  in  1  1 = auto-reload (periodic), 0 = one-shot.
- pause  in  1  freeze counting while high.
- abort  in  1  terminate current run.
- count  out  N  registered counter value.
- dir  out  1  current direction: 1 up, 0 down.
- busy  out  1  high in RUN state.
- tc_pulse  out  1  one-cycle registered pulse at each terminal event.
- done_pulse  out  1  one-cycle registered pulse when a one-shot run completes.

Behaviour:
- Clocking and reset: one clock. Reset is synchronous, active-high. Ports are named clk and rst.
- Reset values: state IDLE, count 0, dir 1, busy 0, tc_pulse 0, done_pulse 0. Latched start/end/mode/reload are cleared to 0. rst mid-run returns to IDLE at the next edge with no pulses.
- States: IDLE, RUN. busy = (state == RUN).
- IDLE:
  - count holds its last value.
  - On an edge with cmd_valid & cmd_ready, latch the command, set count <= cmd_start and dir <= (mode != 01), and go to RUN.
- Priority per edge: rst > abort > pause > counting.
- abort: in RUN, go to IDLE; count and dir hold; no tc_pulse or done_pulse. In IDLE, abort is ignored and a simultaneous command is still accepted.
- pause: in RUN, count, dir and state hold; pulses are 0.
- Pulse defaults: tc_pulse and done_pulse are 0 on every edge unless set below.
- Up mode (and mode 11), on each RUN edge:
  - If count == end: tc_pulse <= 1. If reload, count <= start; else state <= IDLE, done_pulse <= 1, count holds.
  - Otherwise count <= count + 1, wrapping modulo 2^N. start > end therefore wraps through 2^N-1 to 0.
- Down mode: mirror of up mode. count <= count - 1, wrapping modulo 2^N; terminal check is count == end.
- Bounce mode (start < end):
  - dir=1 and count == end: dir <= 0, count <= end - 1, no pulse.
  - dir=0 and count == start: tc_pulse <= 1. If reload, dir <= 1 and count <= start + 1; else IDLE with done_pulse <= 1.
  - Otherwise step by ±1 according to dir.
- Bounce mode with start >= end: count holds start and every RUN edge is a terminal event, handled as in up mode.
- Latency:
  - Accept on edge E0, so count = start after E0.
  - One-shot up/down presents every value from start to end, one per cycle.
  - done_pulse is visible the cycle after count == end is first observed.
  - Run length = |end - start| mod 2^N + 1 cycles of busy.
  - Auto-reload period: |end - start| + 1 cycles for up/down; 2·(end - start) cycles for bounce.
  - start == end in up/down: tc_pulse every cycle when reloading; done after 1 busy cycle when one-shot.
- Back-to-back commands: cmd_ready is high in the cycle done_pulse is high (state is IDLE), so a new command may be accepted on that edge. Commands presented while busy are not accepted and not queued.

Test Plan:
- Reset: rst=1 for 2 cycles -> count=0, dir=1, busy=0, cmd_ready=0; after release cmd_ready=1.
- One-shot up, start=3 end=6 -> count 3,4,5,6 on successive cycles; then tc_pulse=1 and done_pulse=1 for exactly one cycle; busy low; count stays 6.
- Auto-reload down, start=2 end=0 -> count sequence 2,1,0,2,1,0…; tc_pulse every 3rd cycle; done_pulse never asserted; abort ends the run with count frozen.
- Bounce reload, start=1 end=3 -> count 1,2,3,2,1,2,3…; dir flips after count 3; tc_pulse once per 4 cycles; pause held 3 cycles mid-run freezes count and dir, then the sequence resumes.
- Wrap, up one-shot, start=254 end=1 (N=8) -> count 254,255,0,1, then done_pulse. A command issued while busy is ignored: cmd_ready=0 and the run is unaffected.
- Simultaneous events:
  - rst and abort together -> reset values.
  - cmd_valid accepted on the same edge done_pulse goes high -> new run starts the next cycle with count=new start.
